// File: rtl/data_memory_controller_pkg.sv
// Shared definitions for the data memory controller: RV32 load/store funct3
// codes, the controller state encoding and access-size decoding helpers.
package mem_ctrl_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  // Unlisted funct3 codes (011/110/111) fall through to a full-word access.
  function automatic size_t access_size(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return SZ_BYTE;
      F3_H, F3_HU: return SZ_HALF;
      default:     return SZ_WORD;
    endcase
  endfunction

  // Halfwords must sit on an even byte, words on a word boundary.
  function automatic logic is_misaligned(input size_t size, input logic [1:0] offset);
    return ((size == SZ_HALF) && offset[0]) ||
           ((size == SZ_WORD) && (offset != 2'b00));
  endfunction

endpackage

// File: rtl/data_memory_controller_if.sv
// Word-organised data memory bus. The controller is the master; the memory
// answers with readdata and holds busywait high until an access completes.
interface mem_bus_if #(
  parameter int ADDR_WIDTH = 6
);

  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [31:0]           mem_writedata;
  logic [31:0]           mem_readdata;
  logic                  mem_busywait;

  modport master (
    output mem_read, mem_write, mem_address, mem_writedata,
    input  mem_readdata, mem_busywait
  );

  modport slave (
    input  mem_read, mem_write, mem_address, mem_writedata,
    output mem_readdata, mem_busywait
  );

endinterface

// File: rtl/data_memory_controller_load_store_align.sv
// Byte/halfword lane handling between the CPU and a word-only memory:
// extracts and extends load lanes, and merges store lanes into a read word.
module load_store_align
  import mem_ctrl_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [31:0] mem_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  size_t       size;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign size      = access_size(funct3);
  assign byte_lane = mem_word[{offset, 3'b000} +: 8];
  assign half_lane = mem_word[{offset[1], 4'b0000} +: 16];

  // Select the addressed lane for loads and splice the store lane into the old word.
  always_comb begin
    // NOTE: both outputs get a default before the case so no path leaves them unassigned, which would infer a latch.
    load_data  = mem_word;
    store_word = store_data;
    case (size)
      SZ_BYTE: begin
        load_data  = (funct3 == F3_BU) ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
        store_word = mem_word;
        store_word[{offset, 3'b000} +: 8] = store_data[7:0];
      end
      SZ_HALF: begin
        load_data  = (funct3 == F3_HU) ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
        store_word = mem_word;
        store_word[{offset[1], 4'b0000} +: 16] = store_data[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_memory_controller.sv
// MEM-stage data memory controller: turns CPU loads/stores into word
// accesses on mem_bus_if, stalls the pipeline while the memory is busy and
// performs read-modify-write for SB/SH.
// Optional build macro MISALIGN_TRAP_EN adds the registered 'misaligned'
// output and skips the memory for misaligned halfword/word requests.
module data_memory_controller
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [2:0]  cpu_funct3,
  input  logic [31:0] cpu_address,
  input  logic [31:0] cpu_writedata,
  output logic [31:0] cpu_readdata,
  output logic        cpu_busywait,
  mem_bus_if.master   mem
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misaligned
`endif
);

  state_t                state, state_n;
  logic [1:0]            off_q, off_n;
  logic [2:0]            f3_q, f3_n;
  logic                  store_q, store_n;
  logic                  rd_n, wr_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [31:0]           wdata_n, rdata_n;
  logic                  req_valid;
  size_t                 req_size;
  logic                  trap_c;
  logic [31:0]           load_data, store_word;
  logic                  unused_addr_hi;

  assign req_valid      = cpu_read ^ cpu_write;
  assign req_size       = access_size(cpu_funct3);
  assign unused_addr_hi = ^cpu_address[31:ADDR_WIDTH+2];

`ifdef MISALIGN_TRAP_EN
  logic mis_n;
  assign trap_c = is_misaligned(req_size, cpu_address[1:0]);
`else
  assign trap_c = 1'b0;
`endif

  load_store_align u_align (
    .offset     (off_q),
    .funct3     (f3_q),
    .mem_word   (mem.mem_readdata),
    .store_data (cpu_writedata),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // Next-state and next-output logic; every registered output is computed here.
  always_comb begin
    state_n      = state;
    off_n        = off_q;
    f3_n         = f3_q;
    store_n      = store_q;
    rd_n         = mem.mem_read;
    wr_n         = mem.mem_write;
    addr_n       = mem.mem_address;
    wdata_n      = mem.mem_writedata;
    rdata_n      = cpu_readdata;
    cpu_busywait = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis_n        = misaligned;
`endif
    case (state)
      IDLE: begin
        if (req_valid) begin
          cpu_busywait = 1'b1;
          off_n        = cpu_address[1:0];
          f3_n         = cpu_funct3;
          store_n      = cpu_write;
          addr_n       = cpu_address[ADDR_WIDTH+1:2];
          if (trap_c) begin
            state_n = DONE;
`ifdef MISALIGN_TRAP_EN
            mis_n   = 1'b1;
`endif
          end else if (cpu_read || (req_size != SZ_WORD)) begin
            state_n = RD;
            rd_n    = 1'b1;
          end else begin
            state_n = WR;
            wr_n    = 1'b1;
            wdata_n = cpu_writedata;
          end
        end
      end
      RD: begin
        cpu_busywait = 1'b1;
        if (!mem.mem_busywait) begin
          rd_n = 1'b0;
          if (store_q) begin
            state_n = WR;
            wr_n    = 1'b1;
            wdata_n = store_word;
          end else begin
            state_n = DONE;
            rdata_n = load_data;
          end
        end
      end
      WR: begin
        cpu_busywait = 1'b1;
        if (!mem.mem_busywait) begin
          state_n = DONE;
          wr_n    = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
`ifdef MISALIGN_TRAP_EN
        mis_n   = 1'b0;
`endif
      end
    endcase
    if (reset) cpu_busywait = 1'b0;
  end

  // State and registered outputs; reset abandons any access in flight.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state             <= IDLE;
      off_q             <= 2'b00;
      f3_q              <= 3'b000;
      store_q           <= 1'b0;
      mem.mem_read      <= 1'b0;
      mem.mem_write     <= 1'b0;
      mem.mem_address   <= '0;
      mem.mem_writedata <= 32'h0;
      cpu_readdata      <= 32'h0;
`ifdef MISALIGN_TRAP_EN
      misaligned        <= 1'b0;
`endif
    end else begin
      state             <= state_n;
      off_q             <= off_n;
      f3_q              <= f3_n;
      store_q           <= store_n;
      mem.mem_read      <= rd_n;
      mem.mem_write     <= wr_n;
      mem.mem_address   <= addr_n;
      mem.mem_writedata <= wdata_n;
      cpu_readdata      <= rdata_n;
`ifdef MISALIGN_TRAP_EN
      misaligned        <= mis_n;
`endif
    end
  end

endmodule

// File: tb/tb_data_memory_controller.sv
// Self-checking bench for data_memory_controller: a word memory with
// programmable busywait, a transaction-level reference model, directed
// literal cases and randomized loads/stores.
module tb_data_memory_controller;

  localparam int AW = 6;
  localparam int NW = 1 << AW;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_read, cpu_write;
  logic [2:0]  cpu_funct3;
  logic [31:0] cpu_address, cpu_writedata;
  logic [31:0] cpu_readdata;
  logic        cpu_busywait;
`ifdef MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  mem_bus_if #(.ADDR_WIDTH(AW)) bus ();

  data_memory_controller #(.ADDR_WIDTH(AW)) dut (
    .clock         (clock),
    .reset         (reset),
    .cpu_read      (cpu_read),
    .cpu_write     (cpu_write),
    .cpu_funct3    (cpu_funct3),
    .cpu_address   (cpu_address),
    .cpu_writedata (cpu_writedata),
    .cpu_readdata  (cpu_readdata),
    .cpu_busywait  (cpu_busywait),
    .mem           (bus)
`ifdef MISALIGN_TRAP_EN
    ,
    .misaligned    (misaligned)
`endif
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory model ----------------
  logic [31:0] seed_arr [NW];
  logic [31:0] mem_arr  [NW];
  logic [31:0] ref_mem  [NW];
  int          reads = 0, writes = 0, wait_total = 0, mw_hi = 0;
  logic [31:0] last_addr = 32'h0;
  int          wait_pct = 0;
  int          hold_req = 0;
  int          hold_used = 0;

  assign bus.mem_readdata = mem_arr[bus.mem_address];

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NW; i++) mem_arr[i] <= seed_arr[i];
    end else begin
      if (bus.mem_read || bus.mem_write) begin
        last_addr = 32'(bus.mem_address);
        if (bus.mem_busywait) wait_total++;
      end
      if (bus.mem_write) mw_hi++;
      if (bus.mem_read && !bus.mem_busywait) reads++;
      if (bus.mem_write && !bus.mem_busywait) begin
        mem_arr[bus.mem_address] <= bus.mem_writedata;
        writes++;
      end
    end
  end

  always @(negedge clock) begin
    if ((bus.mem_read || bus.mem_write) && (hold_used < hold_req)) begin
      bus.mem_busywait = 1'b1;
      hold_used++;
    end else if (hold_used < hold_req) begin
      bus.mem_busywait = 1'b0;
    end else begin
      bus.mem_busywait = ($urandom_range(0, 99) < wait_pct);
    end
  end

  // ---------------- reference model ----------------
  function automatic int nbytes_of(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] old, input logic [1:0] off,
                                             input logic [2:0] f3);
    int n = nbytes_of(f3);
    logic [31:0] v;
    if (n == 4) return old;
    if (n == 1) begin
      v = (old >> (8 * int'(off))) & 32'hFF;
      if (f3 == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
    end else begin
      v = (old >> (16 * int'(off[1]))) & 32'hFFFF;
      if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [1:0] off,
                                              input logic [2:0] f3, input logic [31:0] wd);
    int n = nbytes_of(f3);
    int sh;
    logic [31:0] mask;
    if (n == 4) return wd;
    sh   = (n == 1) ? 8 * int'(off) : 16 * int'(off[1]);
    mask = ((n == 1) ? 32'hFF : 32'hFFFF) << sh;
    return (old & ~mask) | ((wd << sh) & mask);
  endfunction

  function automatic logic model_misaligned(input logic [2:0] f3, input logic [1:0] off);
`ifdef MISALIGN_TRAP_EN
    int n = nbytes_of(f3);
    return (n == 2 && off[0]) || (n == 4 && off != 2'b00);
`else
    return (f3 == 3'd7) && (off == 2'b11) && 1'b0;
`endif
  endfunction

  // ---------------- per-cycle bus compare ----------------
  logic          mon_active = 1'b0;
  logic [AW-1:0] exp_wa = '0;
  logic [31:0]   exp_wword = 32'h0;

  always @(negedge clock) begin
    if (bus.mem_read || bus.mem_write) begin
      check("rw_exclusive", {31'h0, bus.mem_read & bus.mem_write}, 32'h0);
      if (mon_active) begin
        check("mem_address", 32'(bus.mem_address), 32'(exp_wa));
        if (bus.mem_write) check("mem_writedata", bus.mem_writedata, exp_wword);
      end
    end
  end

  // ---------------- transaction driver ----------------
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] got_data, output int got_stall);
    logic [AW-1:0] wa;
    logic [1:0]    off;
    logic          valid, mis;
    logic [31:0]   exp_ld, exp_st;
    int            n, r0, w0, t0, exp_stall;
    wa     = addr[AW+1:2];
    off    = addr[1:0];
    n      = nbytes_of(f3);
    valid  = rd ^ wr;
    mis    = valid && model_misaligned(f3, off);
    exp_ld = model_load(ref_mem[wa], off, f3);
    exp_st = model_store(ref_mem[wa], off, f3, wd);
    exp_wa     = wa;
    exp_wword  = exp_st;
    mon_active = valid && !mis;
    r0 = reads; w0 = writes; t0 = wait_total;
    @(negedge clock);
    cpu_read = rd; cpu_write = wr; cpu_funct3 = f3; cpu_address = addr; cpu_writedata = wd;
    #1;
    got_stall = 0;
    while (cpu_busywait && got_stall < 200) begin
      got_stall++;
      @(negedge clock);
      #1;
    end
    if (got_stall >= 200) check("stall_timeout", 32'(got_stall), 32'd0);
    got_data = cpu_readdata;
    if (!valid) begin
      exp_stall = 0;
      repeat (3) begin
        @(negedge clock);
        #1;
        check("noop_busywait", {31'h0, cpu_busywait}, 32'h0);
      end
    end else if (mis) begin
      exp_stall = 1;
    end else begin
      exp_stall = ((rd || n == 4) ? 2 : 3) + (wait_total - t0);
    end
    check("stall_cycles", 32'(got_stall), 32'(exp_stall));
    check("read_count", 32'(reads - r0), (valid && !mis && (rd || n < 4)) ? 32'd1 : 32'd0);
    check("write_count", 32'(writes - w0), (valid && !mis && wr) ? 32'd1 : 32'd0);
`ifdef MISALIGN_TRAP_EN
    if (valid) check("misaligned", {31'h0, misaligned}, {31'h0, mis});
`endif
    if (valid && !mis && rd) check("load_data", got_data, exp_ld);
    if (valid && !mis && wr) begin
      ref_mem[wa] = exp_st;
      check("mem_word", mem_arr[wa], ref_mem[wa]);
    end
    @(negedge clock);
    cpu_read = 1'b0; cpu_write = 1'b0;
    mon_active = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] d;
  int          s, mh0, w0;

  initial begin
    reset = 1'b1;
    cpu_read = 1'b0; cpu_write = 1'b0; cpu_funct3 = 3'd0;
    cpu_address = 32'h0; cpu_writedata = 32'h0;
    for (int i = 0; i < NW; i++) seed_arr[i] = $urandom;
    seed_arr[5] = 32'hDEAD_BEEF;
    for (int i = 0; i < NW; i++) ref_mem[i] = seed_arr[i];

    // Reset state, including no stall while reset is high with a request present.
    @(negedge clock);
    cpu_read = 1'b1;
    @(negedge clock);
    #1;
    check("rst_busywait", {31'h0, cpu_busywait}, 32'h0);
    check("rst_mem_read", {31'h0, bus.mem_read}, 32'h0);
    check("rst_mem_write", {31'h0, bus.mem_write}, 32'h0);
    check("rst_mem_address", 32'(bus.mem_address), 32'h0);
    check("rst_mem_writedata", bus.mem_writedata, 32'h0);
    check("rst_cpu_readdata", cpu_readdata, 32'h0);
    cpu_read = 1'b0;
    reset = 1'b0;

    // LW from word 5, zero-wait memory.
    access(1'b1, 1'b0, 3'b010, 32'h14, 32'h0, d, s);
    check("t1_lw_data", d, 32'hDEAD_BEEF);
    check("t1_lw_stall", 32'(s), 32'd2);
    check("t1_lw_addr", last_addr, 32'd5);

    // Byte/halfword extraction and extension.
    access(1'b1, 1'b0, 3'b000, 32'h15, 32'h0, d, s);
    check("t2_lb", d, 32'hFFFF_FFBE);
    access(1'b1, 1'b0, 3'b100, 32'h15, 32'h0, d, s);
    check("t2_lbu", d, 32'h0000_00BE);
    access(1'b1, 1'b0, 3'b001, 32'h16, 32'h0, d, s);
    check("t2_lh", d, 32'hFFFF_DEAD);
    access(1'b1, 1'b0, 3'b101, 32'h16, 32'h0, d, s);
    check("t2_lhu", d, 32'h0000_DEAD);

    // SB read-modify-write.
    access(1'b0, 1'b1, 3'b000, 32'h17, 32'h0000_0012, d, s);
    check("t3_sb_stall", 32'(s), 32'd3);
    check("t3_sb_word", mem_arr[5], 32'h12AD_BEEF);

    // SW with three memory wait cycles.
    hold_req = hold_used + 3;
    mh0 = mw_hi; w0 = writes;
    access(1'b0, 1'b1, 3'b010, 32'h20, 32'hCAFE_F00D, d, s);
    check("t4_sw_stall", 32'(s), 32'd5);
    check("t4_sw_write_hi", 32'(mw_hi - mh0), 32'd4);
    check("t4_sw_writes", 32'(writes - w0), 32'd1);
    check("t4_sw_word", mem_arr[8], 32'hCAFE_F00D);

    // Reset while an SH is waiting in its read phase.
    hold_req = hold_used + 4;
    mh0 = mw_hi;
    @(negedge clock);
    cpu_write = 1'b1; cpu_funct3 = 3'b001; cpu_address = 32'h16; cpu_writedata = 32'h5555;
    @(negedge clock);
    #1;
    check("t5_rd_before_reset", {31'h0, bus.mem_read}, 32'h1);
    reset = 1'b1;
    @(negedge clock);
    #1;
    check("t5_rst_mem_read", {31'h0, bus.mem_read}, 32'h0);
    check("t5_rst_mem_write", {31'h0, bus.mem_write}, 32'h0);
    check("t5_rst_mem_address", 32'(bus.mem_address), 32'h0);
    check("t5_rst_mem_writedata", bus.mem_writedata, 32'h0);
    check("t5_rst_cpu_readdata", cpu_readdata, 32'h0);
    check("t5_rst_busywait", {31'h0, cpu_busywait}, 32'h0);
    reset = 1'b0;
    cpu_write = 1'b0;
    hold_req = hold_used;
    for (int i = 0; i < NW; i++) ref_mem[i] = seed_arr[i];
    repeat (4) @(negedge clock);
    check("t5_no_write_pulse", 32'(mw_hi - mh0), 32'd0);

    // Both request lines high: no access, no stall.
    access(1'b1, 1'b1, 3'b010, 32'h14, 32'h1234_5678, d, s);
    check("t5_noop_stall", 32'(s), 32'd0);

`ifdef MISALIGN_TRAP_EN
    // Misaligned LW traps without touching memory.
    w0 = reads;
    access(1'b1, 1'b0, 3'b010, 32'h16, 32'h0, d, s);
    check("t6_mis_stall", 32'(s), 32'd1);
    check("t6_mis_no_read", 32'(reads - w0), 32'd0);
`endif

    // Randomized traffic with random memory wait states.
    wait_pct = 30;
    for (int i = 0; i < 300; i++) begin
      int          r;
      logic        rd, wr;
      logic [2:0]  f3;
      r = $urandom_range(0, 99);
      if (r < 5) begin
        rd = 1'b1; wr = 1'b1; f3 = 3'($urandom_range(0, 7));
      end else if (r < 55) begin
        rd = 1'b1; wr = 1'b0; f3 = 3'($urandom_range(0, 7));
      end else begin
        rd = 1'b0; wr = 1'b1; f3 = 3'($urandom_range(0, 2));
      end
      access(rd, wr, f3, $urandom, $urandom, d, s);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_memory_controller.md
Name: data_memory_controller

Overview:
- MEM-stage initiator for the word-organised data memory: takes CPU load/store requests and drives the memory's read/write/address/writedata interface.
- Waits on the memory's busywait handshake and stalls the pipeline through cpu_busywait.
- Performs RV32 byte/halfword lane extraction, sign/zero extension, and read-modify-write for SB/SH, since memory accesses whole words only.

Parameters:
ADDR_WIDTH, 6, memory word-address width; mem_address = cpu_address[ADDR_WIDTH+1:2]

Ports:
clock  in  1  system clock; all state on rising edge
reset  in  1  synchronous, active-high reset
cpu_read  in  1  load request from MEM stage
cpu_write  in  1  store request from MEM stage
cpu_funct3  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
cpu_address  in  32  byte address
cpu_writedata  in  32  store data (rs2)
cpu_readdata  out  32  extended load result; registered
cpu_busywait  out  1  stall to pipeline
mem_read  out  1  word read request; registered
mem_write  out  1  word write request; registered
mem_address  out  ADDR_WIDTH  word address; registered
mem_writedata  out  32  word to write; registered
mem_readdata  in  32  word returned by memory
mem_busywait  in  1  memory busy; access completes on a rising edge where request=1 and mem_busywait=0

Behaviour:
- Reset:
  - State forced to IDLE.
  - mem_read=0, mem_write=0, mem_address=0, mem_writedata=0, cpu_readdata=0.
  - cpu_busywait=0 while reset is high.
  - Reset mid-access abandons the access; requests drop on the edge where reset is sampled, and no partial write is reissued.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - A valid request is exactly one of cpu_read/cpu_write.
  - cpu_busywait=1 combinationally when a valid request is present.
  - Next edge latches byte offset, funct3 and word address.
  - Load or SB/SH go to RD with mem_read=1. SW goes to WR with mem_write=1 and mem_writedata=cpu_writedata.
  - cpu_read=cpu_write=1 is a no-op: no stall, no access.
- RD: cpu_busywait=1; the request is held stable until completion. On completion:
  - Load: extract lane by offset, sign-extend (B/H) or zero-extend (BU/HU), register into cpu_readdata, go to DONE, mem_read=0.
  - SB/SH: merge the store lane(s) into mem_readdata, load mem_writedata, mem_read=0, mem_write=1, go to WR (no idle cycle between).
- WR: cpu_busywait=1. On completion, mem_write=0 and go to DONE.
- DONE:
  - cpu_busywait=0 for exactly one cycle so the pipeline advances.
  - The still-present request is ignored.
  - Return to IDLE.
- Latency with zero-wait memory: load/SW stall 2 cycles; SB/SH stall 3 cycles. Each memory wait cycle adds 1.
- Lanes:
  - Byte k = bits [8k+7:8k].
  - Halfword uses offset[1]; offset[0] is ignored.
  - Word ignores offset[1:0].
- funct3 011/110/111 are treated as word.
- mem_read and mem_write are never high together.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - Halfword with offset[0]=1 or word with offset[1:0]≠0 is misaligned.
  - A misaligned request performs no memory access; output misaligned (1 bit, registered) is 1 in DONE.
  - Otherwise the request follows the normal path with misaligned=0; reset value 0.
  - Stall is 1 cycle (IDLE→DONE).
- Undefined: no port; low bits ignored as above.

Decomposition:
- Package mem_ctrl_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the state typedef/encodings.
- Sub-module load_store_align (combinational): load extract/extend and store merge, from offset, funct3 and the two data words.

Test Plan:
1. LW addr 0x0000_0014, memory word 5 = 0xDEADBEEF, zero-wait → mem_address=5, cpu_readdata=0xDEADBEEF, cpu_busywait high 2 cycles.
2. LB addr 0x15 on word 0xDEADBEEF → 0xFFFFFFBE; LBU → 0x000000BE; LH addr 0x16 → 0xFFFFDEAD; LHU → 0x0000DEAD.
3. SB addr 0x17, data 0x0000_0012, word 5 = 0xDEADBEEF → read, then write 0x12ADBEEF; 3 stall cycles; mem_read/mem_write never overlap.
4. SW with mem_busywait held 3 cycles → mem_write held stable 4 cycles, cpu_busywait deasserts only in DONE, single write observed.
5. Reset asserted in RD of an SH → next cycle IDLE, all outputs 0, no mem_write ever pulsed; cpu_read=cpu_write=1 → no access, no stall.
6. (MISALIGN_TRAP_EN) LW addr 0x16 → misaligned=1, no mem_read, 1 stall cycle.
